mod_arith_seq: RTL and testbench



---
 rtl/mod_arith_seq.sv | 167 ++++++++++++++++
 tb/tb_mod_arith_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_arith_seq.sv
// Bit-serial modular arithmetic unit: A*B, A^2, A+B, A-B mod a runtime modulus q.
// One request in flight at a time; results held in registers until the consumer accepts them.
module mod_arith_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_mode,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [DATA_WIDTH-1:0] in_q,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_err,
    output logic [1:0]            dbg_state
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] MODE_MUL = 2'd0;
    localparam logic [1:0] MODE_ADD = 2'd1;
    localparam logic [1:0] MODE_SUB = 2'd2;
    localparam logic [1:0] MODE_SQR = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_ADDSUB = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_q;
    logic [1:0]       r_mode;
    logic [TAG_WIDTH-1:0] r_tag;
    logic             r_err;
    logic [W-1:0]     r_acc;
    logic [CW-1:0]    r_cnt;
    logic [W-1:0]     r_out_data;
    logic [TAG_WIDTH-1:0] r_out_tag;
    logic             r_out_err;

    logic             w_accept;
    logic [W-1:0]     w_b_eff;
    logic             w_in_err;
    logic [W+1:0]     w_s;
    logic [W+1:0]     w_q1;
    logic [W+1:0]     w_q2;
    logic [W+1:0]     w_red;
    logic [W-1:0]     w_acc_next;
    logic [W:0]       w_sum;
    logic [W:0]       w_diff;
    logic [W:0]       w_as;
    logic [W-1:0]     w_as_res;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, so the two never coincide.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign out_err   = r_out_err;
    assign dbg_state = r_state;

    assign w_accept = in_valid & (r_state == S_IDLE);
    assign w_b_eff  = (in_mode == MODE_SQR) ? in_a : in_b;
    assign w_in_err = (in_q < W'(2)) | (in_a >= in_q) | (w_b_eff >= in_q);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_mode == MODE_ADD || in_mode == MODE_SUB) w_next_state = S_ADDSUB;
                    else                                           w_next_state = S_RUN;
                end
            end
            S_RUN:    if (r_cnt == '0) w_next_state = S_DONE;
            S_ADDSUB: w_next_state = S_DONE;
            S_DONE:   if (out_ready) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Interleaved reduction: C < q keeps 2C + B below 3q, so two conditional subtracts suffice.
    always_comb begin
        w_q1 = {2'b00, r_q};
        w_q2 = {1'b0, r_q, 1'b0};
        w_s  = {1'b0, r_acc, 1'b0} + (r_a[r_cnt] ? {2'b00, r_b} : '0);
        if (w_s >= w_q2)      w_red = w_s - w_q2;
        else if (w_s >= w_q1) w_red = w_s - w_q1;
        else                  w_red = w_s;
        w_acc_next = w_red[W-1:0];
    end

    always_comb begin
        w_sum  = {1'b0, r_a} + {1'b0, r_b};
        w_diff = {1'b0, r_a} - {1'b0, r_b};
        if (r_mode == MODE_SUB) begin
            if (r_a >= r_b) w_as = w_diff;
            else            w_as = w_diff + {1'b0, r_q};
        end else begin
            if (w_sum >= {1'b0, r_q}) w_as = w_sum - {1'b0, r_q};
            else                      w_as = w_sum;
        end
        w_as_res = w_as[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_q        <= '0;
            r_mode     <= MODE_MUL;
            r_tag      <= '0;
            r_err      <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_out_data <= '0;
            r_out_tag  <= '0;
            r_out_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a    <= in_a;
                        r_b    <= w_b_eff;
                        r_q    <= in_q;
                        r_mode <= in_mode;
                        r_tag  <= in_tag;
                        r_err  <= w_in_err;
                        r_acc  <= '0;
                        r_cnt  <= CW'(W - 1);
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_out_data <= r_err ? '0 : w_acc_next;
                        r_out_tag  <= r_tag;
                        r_out_err  <= r_err;
                    end
                end
                S_ADDSUB: begin
                    r_out_data <= r_err ? '0 : w_as_res;
                    r_out_tag  <= r_tag;
                    r_out_err  <= r_err;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_arith_seq.sv
// Bench for mod_arith_seq: directed cases on an 8-bit instance, random mixed regression on a
// 32-bit instance, both checked by queue-based scoreboards fed at accept time.
module tb_mod_arith_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 8-bit instance
  logic       v8_in_valid = 1'b0, v8_in_ready, v8_out_valid, v8_out_ready = 1'b1, v8_out_err;
  logic [1:0] v8_mode = 2'd0, v8_dbg;
  logic [7:0] v8_a = '0, v8_b = '0, v8_q = '0, v8_out_data;
  logic [3:0] v8_tag = '0, v8_out_tag;

  // 32-bit instance
  logic        v32_in_valid = 1'b0, v32_in_ready, v32_out_valid, v32_out_ready = 1'b1, v32_out_err;
  logic [1:0]  v32_mode = 2'd0, v32_dbg;
  logic [31:0] v32_a = '0, v32_b = '0, v32_q = '0, v32_out_data;
  logic [3:0]  v32_tag = '0, v32_out_tag;

  mod_arith_seq #(.DATA_WIDTH(8), .TAG_WIDTH(4)) u8 (
    .clk(clk), .reset(reset), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
    .in_mode(v8_mode), .in_a(v8_a), .in_b(v8_b), .in_q(v8_q), .in_tag(v8_tag),
    .out_valid(v8_out_valid), .out_ready(v8_out_ready), .out_data(v8_out_data),
    .out_tag(v8_out_tag), .out_err(v8_out_err), .dbg_state(v8_dbg)
  );

  mod_arith_seq #(.DATA_WIDTH(32), .TAG_WIDTH(4)) u32 (
    .clk(clk), .reset(reset), .in_valid(v32_in_valid), .in_ready(v32_in_ready),
    .in_mode(v32_mode), .in_a(v32_a), .in_b(v32_b), .in_q(v32_q), .in_tag(v32_tag),
    .out_valid(v32_out_valid), .out_ready(v32_out_ready), .out_data(v32_out_data),
    .out_tag(v32_out_tag), .out_err(v32_out_err), .dbg_state(v32_dbg)
  );

  // expected entries are {err, tag, data}
  logic [12:0] exp8_q[$];
  logic [36:0] exp32_q[$];
  int          lat8_q[$];
  int          lat32_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain modular arithmetic on 64-bit integers.
  function automatic logic [32:0] model32(input logic [1:0] m, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] q);
    longint unsigned la, lb, lq, r;
    logic err;
    la  = a;
    lb  = (m == 2'd3) ? a : b;
    lq  = q;
    err = (lq < 2) || (la >= lq) || (lb >= lq);
    r   = 0;
    if (!err) begin
      case (m)
        2'd1:    r = (la + lb) % lq;
        2'd2:    r = (la + lq - lb) % lq;
        default: r = (la * lb) % lq;
      endcase
    end
    return {err, r[31:0]};
  endfunction

  task automatic issue8(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] q, input logic [3:0] tag,
                        input logic [7:0] ed, input logic ee);
    int n = 0;
    while (!v8_in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("in_ready8_timeout", 1, 0);
    v8_mode = m; v8_a = a; v8_b = b; v8_q = q; v8_tag = tag; v8_in_valid = 1'b1;
    exp8_q.push_back({ee, tag, ed});
    @(posedge clk); #1;
    lat8_q.push_back(cyc + ((m == 2'd1 || m == 2'd2) ? 1 : 8));
    v8_in_valid = 1'b0;
    v8_mode = 2'($urandom); v8_a = 8'($urandom); v8_b = 8'($urandom); v8_q = 8'($urandom);
    v8_tag = 4'($urandom);
  endtask

  task automatic issue32(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [3:0] tag);
    int n = 0;
    logic [32:0] r;
    while (!v32_in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("in_ready32_timeout", 1, 0);
    r = model32(m, a, b, q);
    v32_mode = m; v32_a = a; v32_b = b; v32_q = q; v32_tag = tag; v32_in_valid = 1'b1;
    exp32_q.push_back({r[32], tag, r[31:0]});
    @(posedge clk); #1;
    lat32_q.push_back(cyc + ((m == 2'd1 || m == 2'd2) ? 1 : 32));
    v32_in_valid = 1'b0;
    v32_mode = 2'($urandom); v32_a = $urandom; v32_b = $urandom; v32_q = $urandom;
  endtask

  task automatic wait_idle8();
    int n = 0;
    while ((!v8_in_ready || exp8_q.size() != 0) && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("idle8_timeout", 1, 0);
  endtask

  // Monitors: latency on the rising edge of out_valid, payload on each output handshake.
  logic prev8 = 1'b0, prev32 = 1'b0;

  always @(negedge clk) begin
    logic [12:0] x;
    if (v8_out_valid && !prev8) begin
      if (lat8_q.size() == 0) chk("lat8_unexpected", 1, 0);
      else chk("lat8", 64'(cyc), 64'(lat8_q.pop_front()));
    end
    prev8 = v8_out_valid;
    if (v8_out_valid && v8_out_ready) begin
      if (exp8_q.size() == 0) chk("out8_unexpected", 1, 0);
      else begin
        x = exp8_q.pop_front();
        chk("out8_data", v8_out_data, x[7:0]);
        chk("out8_tag", v8_out_tag, x[11:8]);
        chk("out8_err", v8_out_err, x[12]);
      end
    end
  end

  always @(negedge clk) begin
    logic [36:0] y;
    if (v32_out_valid && !prev32) begin
      if (lat32_q.size() == 0) chk("lat32_unexpected", 1, 0);
      else chk("lat32", 64'(cyc), 64'(lat32_q.pop_front()));
    end
    prev32 = v32_out_valid;
    if (v32_out_valid && v32_out_ready) begin
      if (exp32_q.size() == 0) chk("out32_unexpected", 1, 0);
      else begin
        y = exp32_q.pop_front();
        chk("out32_data", v32_out_data, y[31:0]);
        chk("out32_tag", v32_out_tag, y[35:32]);
        chk("out32_err", v32_out_err, y[36]);
      end
    end
  end

  logic rand_ready = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      v32_out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    int n;
    logic stayed_low;
    logic [1:0] m;
    logic [31:0] q, a, b;

    // clock/reset
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", v8_in_ready, 1);
    chk("rst_out_valid", v8_out_valid, 0);
    chk("rst_out_data", v8_out_data, 0);
    chk("rst_out_tag", v8_out_tag, 0);
    chk("rst_out_err", v8_out_err, 0);
    chk("rst_in_ready32", v32_in_ready, 1);
    reset = 1'b0;
    @(posedge clk); #1;

    // directed, W=8
    issue8(2'd0, 8'd200, 8'd100, 8'd251, 4'd5, 8'd171, 1'b0);
    issue8(2'd3, 8'd250, 8'd77,  8'd251, 4'd1, 8'd1,   1'b0);
    issue8(2'd3, 8'd0,   8'd200, 8'd251, 4'd2, 8'd0,   1'b0);
    issue8(2'd3, 8'd1,   8'd9,   8'd251, 4'd3, 8'd1,   1'b0);
    issue8(2'd1, 8'd200, 8'd100, 8'd251, 4'd4, 8'd49,  1'b0);
    issue8(2'd2, 8'd100, 8'd200, 8'd251, 4'd6, 8'd151, 1'b0);
    issue8(2'd2, 8'd200, 8'd100, 8'd251, 4'd7, 8'd100, 1'b0);
    issue8(2'd1, 8'd0,   8'd0,   8'd251, 4'd8, 8'd0,   1'b0);
    issue8(2'd0, 8'd251, 8'd3,   8'd251, 4'd10, 8'd0,  1'b1);
    issue8(2'd1, 8'd0,   8'd0,   8'd1,   4'd11, 8'd0,  1'b1);
    issue8(2'd2, 8'd5,   8'd251, 8'd251, 4'd12, 8'd0,  1'b1);
    issue8(2'd0, 8'd254, 8'd254, 8'd255, 4'd13, 8'd1,  1'b0);
    wait_idle8();

    // back-pressure with a concurrent request that must be ignored
    v8_out_ready = 1'b0;
    issue8(2'd1, 8'd200, 8'd100, 8'd251, 4'd9, 8'd49, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      v8_in_valid = 1'b1; v8_mode = 2'd1; v8_a = 8'd1; v8_b = 8'd1; v8_q = 8'd251;
      chk("bp_out_valid", v8_out_valid, 1);
      chk("bp_in_ready", v8_in_ready, 0);
      chk("bp_data", v8_out_data, 49);
      chk("bp_tag", v8_out_tag, 9);
      chk("bp_err", v8_out_err, 0);
      @(posedge clk); #1;
    end
    v8_in_valid = 1'b0;
    v8_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", v8_in_ready, 1);
    chk("bp_release_out_valid", v8_out_valid, 0);
    stayed_low = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (v8_out_valid) stayed_low = 1'b0; end
    chk("bp_no_accept", stayed_low, 1);

    // reset during RUN with bit 3 in progress
    issue8(2'd0, 8'd3, 8'd5, 8'd251, 4'd14, 8'd15, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(exp8_q.pop_back());
    void'(lat8_q.pop_back());
    chk("rr_out_valid", v8_out_valid, 0);
    chk("rr_in_ready", v8_in_ready, 1);
    chk("rr_out_data", v8_out_data, 0);
    @(posedge clk); #1;
    chk("rr_idle_hold", v8_in_ready, 1);
    stayed_low = 1'b1;
    repeat (12) begin @(posedge clk); #1; if (v8_out_valid) stayed_low = 1'b0; end
    chk("rr_no_output", stayed_low, 1);
    issue8(2'd0, 8'd200, 8'd100, 8'd251, 4'd15, 8'd171, 1'b0);
    wait_idle8();

    // random mixed regression, W=32, random consumer back-pressure
    rand_ready = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      m = 2'($urandom_range(0, 3));
      n = $urandom_range(0, 15);
      if (n == 0)      q = 32'($urandom_range(0, 1));
      else if (n < 4)  q = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      else begin q = $urandom; if (q < 2) q = 2; end
      if (q < 2 || $urandom_range(0, 15) == 0) a = $urandom;
      else if ($urandom_range(0, 7) == 0) a = q - 1;
      else a = $urandom % q;
      if (q < 2 || $urandom_range(0, 15) == 0) b = $urandom;
      else if ($urandom_range(0, 7) == 0) b = q - 1;
      else b = $urandom % q;
      issue32(m, a, b, q, 4'($urandom_range(0, 15)));
    end

    n = 0;
    while ((exp32_q.size() != 0 || exp8_q.size() != 0) && n < 5000) begin
      @(posedge clk); n++;
    end
    chk("drain_pending", 64'(exp32_q.size() + exp8_q.size()), 0);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
